// File: rtl/xbar_arbiter_pkg.sv
// Shared types and sizes for the 2x2 crossbar arbiter.
package pkg_xarb;

    localparam int N_MST = 2;
    localparam int N_SLV = 2;
    localparam int TO_W  = 8;

    typedef enum logic {ARB_IDLE, ARB_BUSY} t_arb_st;

    // Turns a master index into a one-hot per-master pulse vector.
    function automatic logic [N_MST-1:0] onehot(input logic idx);
        logic [N_MST-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/xbar_arb_slot.sv
// One slave slot: round-robin winner selection, IDLE/BUSY sequencing and a
// watchdog that releases the slave if it never acknowledges.
module xbar_arb_slot
    import pkg_xarb::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_MST-1:0] elig,
    input  logic             ack,
    output logic [N_MST-1:0] take,
    output logic             valid,
    output logic             owner,
    output logic [N_MST-1:0] gnt,
    output logic [N_MST-1:0] done,
    output logic [N_MST-1:0] err
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    t_arb_st         state;
    logic            last;
    logic [TO_W-1:0] wdog;

    // Winner this cycle: only an idle slot grants; on contention the master that did not win last time goes first.
    always_comb begin
        take = '0;
        if (state == ARB_IDLE) begin
            if (&elig) begin
                take = onehot(~last);
            end else begin
                take = elig;
            end
        end
    end

    // Slot FSM with registered pulses; an ack on the timeout cycle is treated as a normal completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            wdog  <= '0;
            valid <= 1'b0;
            gnt   <= '0;
            done  <= '0;
            err   <= '0;
        end else begin
            valid <= 1'b0;
            gnt   <= '0;
            done  <= '0;
            err   <= '0;
            if (state == ARB_IDLE) begin
                if (|take) begin
                    state <= ARB_BUSY;
                    owner <= take[1];
                    last  <= take[1];
                    valid <= 1'b1;
                    gnt   <= take;
                    wdog  <= '0;
                end
            end else begin
                if (ack) begin
                    state <= ARB_IDLE;
                    done  <= onehot(owner);
                end else if (wdog == WD_LAST) begin
                    state <= ARB_IDLE;
                    err   <= onehot(owner);
                end else begin
                    wdog <= wdog + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/xbar_arbiter.sv
// Top of the crossbar arbiter: tracks outstanding masters, steers read data
// back to each master and merges the two slot pulse streams.
module xbar_arbiter
    import pkg_xarb::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_MST-1:0] m_req,
    input  logic [N_MST-1:0] m_sel,
    output logic [N_MST-1:0] m_gnt,
    output logic [N_MST-1:0] m_done,
    output logic [N_MST-1:0] m_err,
    output logic [N_SLV-1:0] s_valid,
    output logic [N_SLV-1:0] s_owner,
    input  logic [N_SLV-1:0] s_ack,
    output logic [N_MST-1:0] rd_route
);

    logic [N_MST-1:0] outstanding;
    logic [N_MST-1:0] busy_mask;
    logic [N_MST-1:0] elig0, elig1;
    logic [N_MST-1:0] take0, take1;
    logic [N_MST-1:0] gnt0, gnt1;
    logic [N_MST-1:0] done0, done1;
    logic [N_MST-1:0] err0, err1;
    logic             valid0, valid1;
    logic             owner0, owner1;

    // A master counts as busy from its grant pulse until its done/err pulse, so it can be re-granted on the pulse cycle itself.
    assign busy_mask = (outstanding | m_gnt) & ~(m_done | m_err);
    assign elig0     = m_req & ~m_sel & ~busy_mask;
    assign elig1     = m_req &  m_sel & ~busy_mask;

    assign m_gnt   = gnt0 | gnt1;
    assign m_done  = done0 | done1;
    assign m_err   = err0 | err1;
    assign s_valid = {valid1, valid0};
    assign s_owner = {owner1, owner0};

    xbar_arb_slot #(.TIMEOUT(TIMEOUT)) u_slot0 (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (elig0),
        .ack   (s_ack[0]),
        .take  (take0),
        .valid (valid0),
        .owner (owner0),
        .gnt   (gnt0),
        .done  (done0),
        .err   (err0)
    );

    xbar_arb_slot #(.TIMEOUT(TIMEOUT)) u_slot1 (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (elig1),
        .ack   (s_ack[1]),
        .take  (take1),
        .valid (valid1),
        .owner (owner1),
        .gnt   (gnt1),
        .done  (done1),
        .err   (err1)
    );

    // Outstanding flags latch the grant pulse and drop once the completion pulse has been seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            outstanding <= (outstanding | m_gnt) & ~(m_done | m_err);
        end
    end

    // Read-data route follows the slave that most recently granted each master and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_route <= '0;
        end else begin
            for (int m = 0; m < N_MST; m++) begin
                if (take0[m]) begin
                    rd_route[m] <= 1'b0;
                end else if (take1[m]) begin
                    rd_route[m] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_xbar_arbiter.sv
// Self-checking bench for xbar_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the arbiter.
module tb_xbar_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rst_n;
    logic [1:0] m_req;
    logic [1:0] m_sel;
    logic [1:0] m_gnt;
    logic [1:0] m_done;
    logic [1:0] m_err;
    logic [1:0] s_valid;
    logic [1:0] s_owner;
    logic [1:0] s_ack;
    logic [1:0] rd_route;

    int evalCount = 0;
    int failCount = 0;

    // model state: who holds each slave, for how long, and who is waiting on a reply
    bit   slvBusy  [2];
    int   slvOwner [2];
    int   slvAge   [2];
    int   slvLast  [2];
    bit   mstPend  [2];
    int   mstRoute [2];
    logic [1:0] expGnt, expDone, expErr, expValid;

    xbar_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req    (m_req),
        .m_sel    (m_sel),
        .m_gnt    (m_gnt),
        .m_done   (m_done),
        .m_err    (m_err),
        .s_valid  (s_valid),
        .s_owner  (s_owner),
        .s_ack    (s_ack),
        .rd_route (rd_route)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports tag/observed/expected when it fails.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        evalCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] sel, input logic [1:0] ack);
        m_req = req;
        m_sel = sel;
        s_ack = ack;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            slvBusy[i]  = 0;
            slvOwner[i] = 0;
            slvAge[i]   = 0;
            slvLast[i]  = 1;
            mstPend[i]  = 0;
            mstRoute[i] = 0;
        end
        expGnt = '0; expDone = '0; expErr = '0; expValid = '0;
    endtask

    // Advances the model across one clock edge using the inputs as currently driven.
    task automatic modelStep();
        bit oldPend [2];
        bit cand0, cand1;
        int win;
        expGnt = '0; expDone = '0; expErr = '0; expValid = '0;
        oldPend = mstPend;
        for (int s = 0; s < 2; s++) begin
            if (!slvBusy[s]) begin
                cand0 = m_req[0] && (int'(m_sel[0]) == s) && !oldPend[0];
                cand1 = m_req[1] && (int'(m_sel[1]) == s) && !oldPend[1];
                if (cand0 && cand1) win = 1 - slvLast[s];
                else if (cand0)     win = 0;
                else if (cand1)     win = 1;
                else                win = -1;
                if (win >= 0) begin
                    slvBusy[s]    = 1;
                    slvAge[s]     = 0;
                    slvOwner[s]   = win;
                    slvLast[s]    = win;
                    mstPend[win]  = 1;
                    mstRoute[win] = s;
                    expValid[s]   = 1'b1;
                    expGnt[win]   = 1'b1;
                end
            end else if (s_ack[s]) begin
                slvBusy[s] = 0;
                mstPend[slvOwner[s]] = 0;
                expDone[slvOwner[s]] = 1'b1;
            end else if (slvAge[s] + 1 == TIMEOUT) begin
                slvBusy[s] = 0;
                mstPend[slvOwner[s]] = 0;
                expErr[slvOwner[s]]  = 1'b1;
            end else begin
                slvAge[s]++;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("m_gnt",    8'(m_gnt),    8'(expGnt));
        checkOutput("m_done",   8'(m_done),   8'(expDone));
        checkOutput("m_err",    8'(m_err),    8'(expErr));
        checkOutput("s_valid",  8'(s_valid),  8'(expValid));
        checkOutput("s_owner",  8'(s_owner),  8'({slvOwner[1][0], slvOwner[0][0]}));
        checkOutput("rd_route", 8'(rd_route), 8'({mstRoute[1][0], mstRoute[0][0]}));
    endtask

    // One cycle: model, clock edge, compare; masters drop requests once granted, acks are single pulses.
    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
        m_req = m_req & ~expGnt;
        s_ack = '0;
    endtask

    initial begin
        logic [1:0] rrOrder [4];
        logic [1:0] zero2;
        int         waitCycles;

        rrOrder = '{2'b01, 2'b10, 2'b01, 2'b10};
        zero2   = 2'b00;

        // reset state
        rst_n = 1'b0;
        applyStimulus(2'b00, 2'b00, 2'b00);
        modelReset();
        #2;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single M0 -> S0 transaction, ack three cycles after valid
        applyStimulus(2'b01, 2'b00, 2'b00);
        tick();
        tick();
        tick();
        s_ack = 2'b01;
        tick();
        tick();

        // M0 -> S0 and M1 -> S1 at once
        applyStimulus(2'b11, 2'b10, 2'b00);
        tick();
        checkOutput("dual_gnt",   8'(m_gnt),    8'(2'b11));
        checkOutput("dual_owner", 8'(s_owner),  8'(2'b10));
        checkOutput("dual_route", 8'(rd_route), 8'(2'b10));
        s_ack = 2'b11;
        tick();
        tick();

        // both masters hammer S1: grants alternate starting with M0
        for (int t = 0; t < 4; t++) begin
            applyStimulus(2'b11, 2'b11, 2'b00);
            tick();
            checkOutput("rr_order", 8'(m_gnt), 8'(rrOrder[t]));
            s_ack = 2'b10;
            tick();
        end
        m_req = 2'b00;
        tick();

        // M1 -> S0 never acked: error pulse TIMEOUT cycles after the grant
        applyStimulus(2'b10, 2'b00, 2'b00);
        tick();
        waitCycles = 0;
        while (m_err[1] !== 1'b1 && waitCycles < 3 * TIMEOUT) begin
            tick();
            waitCycles++;
        end
        checkOutput("timeout_dist", 8'(waitCycles), 8'(TIMEOUT));
        checkOutput("timeout_nodone", 8'(m_done), 8'(zero2));
        tick();

        // ack on the very cycle the watchdog would fire
        applyStimulus(2'b01, 2'b00, 2'b00);
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        s_ack = 2'b01;
        tick();
        checkOutput("ack_vs_to_done", 8'(m_done), 8'(2'b01));
        checkOutput("ack_vs_to_err",  8'(m_err),  8'(zero2));

        // ack while idle does nothing
        applyStimulus(2'b00, 2'b00, 2'b11);
        tick();
        checkOutput("idle_ack_done",  8'(m_done),  8'(zero2));
        checkOutput("idle_ack_valid", 8'(s_valid), 8'(zero2));

        // reset while S0 is busy, then contention goes to M0
        applyStimulus(2'b01, 2'b00, 2'b00);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        applyStimulus(2'b11, 2'b00, 2'b00);
        tick();
        checkOutput("post_reset_rr", 8'(m_gnt), 8'(2'b01));
        s_ack = 2'b01;
        tick();
        tick();

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!m_req[m] && !mstPend[m] && ($urandom % 4 == 0)) begin
                    m_req[m] = 1'b1;
                    m_sel[m] = 1'($urandom_range(0, 1));
                end
            end
            for (int s = 0; s < 2; s++) begin
                s_ack[s] = ($urandom % 7 == 0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
        $finish;
    end

endmodule
